alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter DW, default 8, operand/result width.
REQ-002 SHALL have parameter OPW, default 4, opcode width.
REQ-003 SHALL have parameter OP_IDLE, default 4'hF, opcode driven to the ALU when no operation is issued (non-ALU code, ALU forwards In1).
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 req0 / req1  in  1  operation request from requester 0 / 1, level, held until grant.
REQ-007 a0, b0 / a1, b1  in  DW  operands of requester 0 / 1, stable while req high.
REQ-008 op0 / op1  in  OPW  opcode of requester 0 / 1, stable while req high.
REQ-009 gnt0 / gnt1  out  1  one-cycle pulse, request and operands accepted.
REQ-010 rdy0 / rdy1  out  1  one-cycle pulse, res0 / res1 updated this cycle.
REQ-011 res0 / res1  out  DW  registered result, held until that requester's next completion.
REQ-012 alu_in1, alu_in2  out  DW  operands to the shared combinational ALU.
REQ-013 alu_op  out  OPW  opcode to the shared ALU.
REQ-014 alu_out  in  DW  ALU result, combinational from alu_in1/alu_in2/alu_op.
REQ-015 busy  out  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, DONE; all outputs registered or decoded from registered state.
REQ-017 IDLE: no req -> stay IDLE; any req -> select winner, latch its a/b/op into issue registers, pulse its gnt in the same cycle, record owner, next state ISSUE.
REQ-018 ISSUE: alu_in1/alu_in2/alu_op driven from issue registers; on the clock edge, alu_out captured into owner's res register; next state DONE.
REQ-019 DONE: owner's rdy high for exactly one cycle, with res already holding the new value; next state IDLE.
REQ-020 Outside ISSUE, alu_in1 and alu_in2 SHALL be 0 and alu_op SHALL be OP_IDLE.
REQ-021 Latency: gnt in cycle N, result capture at end of N+1, rdy in cycle N+2; throughput one operation per 3 cycles.
REQ-022 Requests arriving while busy SHALL be ignored until IDLE; no request is lost if req is held.
REQ-023 req still high in the cycle after gnt SHALL be treated as a new request at the next IDLE.
REQ-024 gnt0 and gnt1 SHALL never be high together; same for rdy0 and rdy1.
REQ-025 Results SHALL be DW bits, truncated (wrap-around) as produced by the ALU; no carry/overflow output.
REQ-026 Non-owner res register SHALL not change during another requester's operation.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, gnt0/1, rdy0/1, busy = 0, res0/res1 = 0, issue registers = 0, alu_op = OP_IDLE.
REQ-028 Reset during ISSUE or DONE SHALL abort the operation: no rdy pulse, res unchanged from reset value 0.
REQ-029 Round-robin last-winner pointer SHALL reset to 1 so requester 0 wins the first contention.

Configuration
REQ-030 Macro ALU_ARB_ROUND_ROBIN_EN defined: on simultaneous req0 and req1, winner is the requester not granted last; pointer updates on every grant.
REQ-031 Macro ALU_ARB_ROUND_ROBIN_EN undefined: fixed priority, requester 0 always wins contention; pointer logic absent.

Verification
REQ-032 Single op: req0, a0=8'h12, b0=8'h34, op0=ADD -> gnt0 at N, rdy0 at N+2, res0=8'h46, busy high N..N+2.
REQ-033 Wrap: req1, a1=8'hF0, b1=8'h20, op1=ADD -> res1=8'h10; SUB a1=8'h00, b1=8'h01 -> res1=8'hFF.
REQ-034 Contention, round-robin build: req0 and req1 both held -> grants 0,1,0,1 every 3 cycles; without macro -> grants 0,0,0 while req0 held, req1 starved.
REQ-035 Isolation: op for requester 1 completes (res1=8'h0F via AND 8'hFF,8'h0F) while res0 holds 8'h46 unchanged; rdy0 never pulses.
REQ-036 Reset mid-op: rst_n low in ISSUE cycle -> busy=0, no rdy pulse, res0=0, alu_op=OP_IDLE; after release, held req0 granted in first IDLE cycle.
REQ-037 Idle drive: no requests for 10 cycles -> alu_in1=alu_in2=0, alu_op=OP_IDLE, all gnt/rdy low.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Handshake bundle between two requesters, the alu_arbiter and a shared combinational ALU.
// slave = arbiter side, master = requester/ALU environment side.
interface alu_arbiter_if #(
  parameter int DW  = 8,
  parameter int OPW = 4
);
  logic           req0, req1;
  logic [DW-1:0]  a0, b0, a1, b1;
  logic [OPW-1:0] op0, op1;
  logic           gnt0, gnt1;
  logic           rdy0, rdy1;
  logic [DW-1:0]  res0, res1;
  logic [DW-1:0]  alu_in1, alu_in2;
  logic [OPW-1:0] alu_op;
  logic [DW-1:0]  alu_out;
  logic           busy;

  modport slave (
    input  req0, req1, a0, b0, op0, a1, b1, op1, alu_out,
    output gnt0, gnt1, rdy0, rdy1, res0, res1, alu_in1, alu_in2, alu_op, busy
  );

  modport master (
    output req0, req1, a0, b0, op0, a1, b1, op1, alu_out,
    input  gnt0, gnt1, rdy0, rdy1, res0, res1, alu_in1, alu_in2, alu_op, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters via IDLE -> ISSUE -> DONE.
// Latency: gnt in cycle N, res captured at end of N+1, rdy in N+2; one operation per 3 cycles.
// Backpressure: req is level-held and ignored while busy; ALU_ARB_ROUND_ROBIN_EN selects round-robin, else fixed priority to requester 0.
module alu_arbiter #(
  parameter int             DW      = 8,
  parameter int             OPW     = 4,
  parameter logic [OPW-1:0] OP_IDLE = 4'hF
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  alu_arbiter_if.slave arb
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [DW-1:0]  in1_q, in1_d;
  logic [DW-1:0]  in2_q, in2_d;
  logic [OPW-1:0] op_q, op_d;
  logic           owner_q, owner_d;
  logic [DW-1:0]  res0_q, res0_d;
  logic [DW-1:0]  res1_q, res1_d;

  logic any_req;
  logic win1;
  logic gnt0_c, gnt1_c;

  assign any_req = arb.req0 | arb.req1;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  // last_q = 1 means requester 1 won most recently, so requester 0 wins the next tie.
  logic last_q, last_d;

  always_comb begin
    win1   = arb.req1 & (~arb.req0 | ~last_q);
    last_d = last_q;
    if (state_q == IDLE && any_req) begin
      last_d = win1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`else
  always_comb begin
    win1 = arb.req1 & ~arb.req0;
  end
`endif

  always_comb begin
    state_d = state_q;
    in1_d   = in1_q;
    in2_d   = in2_q;
    op_d    = op_q;
    owner_d = owner_q;
    res0_d  = res0_q;
    res1_d  = res1_q;
    gnt0_c  = 1'b0;
    gnt1_c  = 1'b0;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt0_c  = ~win1;
          gnt1_c  = win1;
          owner_d = win1;
          in1_d   = win1 ? arb.a1  : arb.a0;
          in2_d   = win1 ? arb.b1  : arb.b0;
          op_d    = win1 ? arb.op1 : arb.op0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (owner_q) begin
          res1_d = arb.alu_out;
        end else begin
          res0_d = arb.alu_out;
        end
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      in1_q   <= '0;
      in2_q   <= '0;
      op_q    <= '0;
      owner_q <= 1'b0;
      res0_q  <= '0;
      res1_q  <= '0;
    end else begin
      state_q <= state_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      op_q    <= op_d;
      owner_q <= owner_d;
      res0_q  <= res0_d;
      res1_q  <= res1_d;
    end
  end

  // Grants are decoded combinationally in IDLE; gating with reset keeps them low the instant reset asserts.
  assign arb.gnt0    = gnt0_c & rst_n_i;
  assign arb.gnt1    = gnt1_c & rst_n_i;
  assign arb.rdy0    = (state_q == DONE) & ~owner_q;
  assign arb.rdy1    = (state_q == DONE) &  owner_q;
  assign arb.res0    = res0_q;
  assign arb.res1    = res1_q;
  assign arb.busy    = (state_q != IDLE) | arb.gnt0 | arb.gnt1;
  assign arb.alu_in1 = (state_q == ISSUE) ? in1_q : '0;
  assign arb.alu_in2 = (state_q == ISSUE) ? in2_q : '0;
  assign arb.alu_op  = (state_q == ISSUE) ? op_q  : OP_IDLE;

  a_gnt_mutex : assert property (@(posedge clk_i) disable iff (!rst_n_i)
    !(arb.gnt0 && arb.gnt1));
  a_rdy_mutex : assert property (@(posedge clk_i) disable iff (!rst_n_i)
    !(arb.rdy0 && arb.rdy1));
  a_issue_done : assert property (@(posedge clk_i) disable iff (!rst_n_i)
    (state_q == ISSUE) |=> (state_q == DONE));

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed vector table, corner-case sequences, then random traffic
// checked against a schedule-based model of grants and completions.
module tb_alu_arbiter;
  localparam int         DW      = 8;
  localparam int         OPW     = 4;
  localparam logic [3:0] OP_IDLE = 4'hF;
  localparam logic [3:0] ADD = 4'h0, SUB = 4'h1, AND_ = 4'h2, OR_ = 4'h3, XOR_ = 4'h4;
`ifdef ALU_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_arbiter_if #(.DW(DW), .OPW(OPW)) bus ();

  alu_arbiter #(.DW(DW), .OPW(OPW), .OP_IDLE(OP_IDLE)) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .arb    (bus)
  );

  function automatic logic [7:0] alu_fn(logic [7:0] a, logic [7:0] b, logic [3:0] op);
    case (op)
      ADD:     return a + b;
      SUB:     return a - b;
      AND_:    return a & b;
      OR_:     return a | b;
      XOR_:    return a ^ b;
      default: return a;
    endcase
  endfunction

  assign bus.alu_out = alu_fn(bus.alu_in1, bus.alu_in2, bus.alu_op);

  int total = 0;
  int bad   = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int i, logic r, logic [7:0] a, logic [7:0] b, logic [3:0] op);
    if (i == 0) begin
      bus.req0 = r; bus.a0 = a; bus.b0 = b; bus.op0 = op;
    end else begin
      bus.req1 = r; bus.a1 = a; bus.b1 = b; bus.op1 = op;
    end
  endtask

  task automatic do_reset();
    drive(0, 1'b0, 8'h00, 8'h00, 4'h0);
    drive(1, 1'b0, 8'h00, 8'h00, 4'h0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  typedef struct {
    logic [1:0] req;
    logic [7:0] a0, b0;
    logic [3:0] op0;
    logic [7:0] a1, b1;
    logic [3:0] op1;
    logic [1:0] gnt;
    logic [7:0] res;
  } vec_t;

  vec_t       vt[7];
  logic [7:0] res_m[2];

  task automatic run_vec(int i);
    vec_t       v;
    int         w;
    logic [7:0] ea, eb;
    logic [3:0] eo;
    v  = vt[i];
    w  = v.gnt[1] ? 1 : 0;
    ea = (w == 1) ? v.a1 : v.a0;
    eb = (w == 1) ? v.b1 : v.b0;
    eo = (w == 1) ? v.op1 : v.op0;
    drive(0, v.req[0], v.a0, v.b0, v.op0);
    drive(1, v.req[1], v.a1, v.b1, v.op1);
    @(negedge clk);
    check($sformatf("v%0d_gnt", i), {bus.gnt1, bus.gnt0}, v.gnt);
    check($sformatf("v%0d_busy_gnt", i), bus.busy, 1);
    tick();
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d_alu_issue", i), {bus.alu_in1, bus.alu_in2, bus.alu_op}, {ea, eb, eo});
    check($sformatf("v%0d_gnt_issue", i), {bus.gnt1, bus.gnt0}, 2'b00);
    tick();
    @(negedge clk);
    check($sformatf("v%0d_rdy", i), {bus.rdy1, bus.rdy0}, v.gnt);
    check($sformatf("v%0d_res_own", i), (w == 1) ? bus.res1 : bus.res0, v.res);
    check($sformatf("v%0d_res_other", i), (w == 1) ? bus.res0 : bus.res1, res_m[1 - w]);
    check($sformatf("v%0d_busy_done", i), bus.busy, 1);
    res_m[w] = v.res;
    tick();
    @(negedge clk);
    check($sformatf("v%0d_after", i), {bus.rdy1, bus.rdy0, bus.busy}, 3'b000);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{2'b01, 8'h12, 8'h34, ADD,  8'h00, 8'h00, ADD,  2'b01, 8'h46};
    vt[1] = '{2'b10, 8'h00, 8'h00, ADD,  8'hF0, 8'h20, ADD,  2'b10, 8'h10};
    vt[2] = '{2'b10, 8'h00, 8'h00, ADD,  8'h00, 8'h01, SUB,  2'b10, 8'hFF};
    vt[3] = '{2'b10, 8'h00, 8'h00, ADD,  8'hFF, 8'h0F, AND_, 2'b10, 8'h0F};
    vt[4] = '{2'b11, 8'h03, 8'h05, XOR_, 8'h07, 8'h09, ADD,  2'b01, 8'h06};
    if (RR) vt[5] = '{2'b11, 8'h10, 8'h01, OR_, 8'h07, 8'h09, ADD, 2'b10, 8'h10};
    else    vt[5] = '{2'b11, 8'h10, 8'h01, OR_, 8'h07, 8'h09, ADD, 2'b01, 8'h11};
    vt[6] = '{2'b01, 8'hAA, 8'h55, OP_IDLE, 8'h00, 8'h00, ADD, 2'b01, 8'hAA};

    // Reset state, with req0 already high to show grants are suppressed.
    drive(0, 1'b1, 8'h12, 8'h34, ADD);
    drive(1, 1'b0, 8'h00, 8'h00, ADD);
    #2;
    check("rst_gnt", {bus.gnt1, bus.gnt0}, 2'b00);
    check("rst_rdy", {bus.rdy1, bus.rdy0}, 2'b00);
    check("rst_busy", bus.busy, 0);
    check("rst_res", {bus.res1, bus.res0}, 16'h0000);
    check("rst_alu", {bus.alu_in1, bus.alu_in2, bus.alu_op}, {8'h00, 8'h00, OP_IDLE});
    do_reset();
    res_m[0] = 8'h00;
    res_m[1] = 8'h00;

    for (int i = 0; i < 7; i++) run_vec(i);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("idle_%0d", i),
            {bus.alu_in1, bus.alu_in2, bus.alu_op, bus.gnt0, bus.gnt1, bus.rdy0, bus.rdy1},
            {8'h00, 8'h00, OP_IDLE, 4'b0000});
      tick();
    end

    // Sustained contention.
    do_reset();
    drive(0, 1'b1, 8'h01, 8'h01, ADD);
    drive(1, 1'b1, 8'h02, 8'h02, ADD);
    begin
      int ng, prev, c;
      ng = 0; prev = -1; c = 0;
      while (ng < 4 && c < 40) begin
        @(negedge clk);
        if (bus.gnt0 || bus.gnt1) begin
          check($sformatf("cont_win_%0d", ng), bus.gnt1, RR ? (ng % 2) : 0);
          if (prev >= 0) check($sformatf("cont_gap_%0d", ng), c - prev, 3);
          prev = c;
          ng++;
        end
        tick();
        c++;
      end
      check("cont_grants", ng, 4);
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    tick(); tick(); tick();

    // Reset asserted in the ISSUE cycle.
    do_reset();
    drive(0, 1'b1, 8'h12, 8'h34, ADD);
    @(negedge clk);
    check("rmid_gnt", bus.gnt0, 1);
    tick();
    check("rmid_issue_op", bus.alu_op, ADD);
    rst_n = 1'b0;
    #1;
    check("rmid_busy", bus.busy, 0);
    check("rmid_op", bus.alu_op, OP_IDLE);
    check("rmid_gnt_low", {bus.gnt1, bus.gnt0}, 2'b00);
    @(posedge clk);
    #1;
    check("rmid_rdy", {bus.rdy1, bus.rdy0}, 2'b00);
    check("rmid_res0", bus.res0, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rmid_regrant", bus.gnt0, 1);
    tick();
    bus.req0 = 1'b0;
    tick();
    @(negedge clk);
    check("rmid_done", {bus.rdy0, bus.res0}, {1'b1, 8'h46});
    tick();

    // Random traffic against a schedule model.
    do_reset();
    begin
      logic       rq[2];
      logic [7:0] ra[2], rb[2];
      logic [3:0] ro[2];
      logic [7:0] rm[2];
      int         free_at, last, iss_cyc, pend_cyc, pend_own, g;
      logic [7:0] iss_a, iss_b, pend_val;
      logic [3:0] iss_op;
      logic [1:0] e_gnt, e_rdy;
      logic [19:0] e_alu;
      for (int i = 0; i < 2; i++) begin
        rq[i] = 1'b0; ra[i] = '0; rb[i] = '0; ro[i] = '0; rm[i] = '0;
      end
      free_at = 0; last = 1; iss_cyc = -1; pend_cyc = -1; pend_own = 0;
      iss_a = '0; iss_b = '0; iss_op = '0; pend_val = '0;
      for (int cyc = 0; cyc < 600; cyc++) begin
        for (int i = 0; i < 2; i++) drive(i, rq[i], ra[i], rb[i], ro[i]);
        g = -1;
        if (cyc >= free_at && (rq[0] || rq[1])) begin
          if (rq[0] && rq[1]) g = RR ? ((last == 1) ? 0 : 1) : 0;
          else                g = rq[0] ? 0 : 1;
          last     = g;
          free_at  = cyc + 3;
          iss_cyc  = cyc + 1;
          iss_a    = ra[g]; iss_b = rb[g]; iss_op = ro[g];
          pend_cyc = cyc + 2;
          pend_own = g;
          pend_val = alu_fn(ra[g], rb[g], ro[g]);
        end
        e_gnt = (g == 0) ? 2'b01 : (g == 1) ? 2'b10 : 2'b00;
        e_rdy = 2'b00;
        if (pend_cyc == cyc) begin
          e_rdy        = (pend_own == 1) ? 2'b10 : 2'b01;
          rm[pend_own] = pend_val;
        end
        e_alu = (iss_cyc == cyc) ? {iss_a, iss_b, iss_op} : {8'h00, 8'h00, OP_IDLE};
        @(negedge clk);
        check($sformatf("rnd%0d_gnt", cyc), {bus.gnt1, bus.gnt0}, e_gnt);
        check($sformatf("rnd%0d_rdy", cyc), {bus.rdy1, bus.rdy0}, e_rdy);
        check($sformatf("rnd%0d_busy", cyc), bus.busy, (cyc < free_at) ? 1 : 0);
        check($sformatf("rnd%0d_res", cyc), {bus.res1, bus.res0}, {rm[1], rm[0]});
        check($sformatf("rnd%0d_alu", cyc), {bus.alu_in1, bus.alu_in2, bus.alu_op}, e_alu);
        tick();
        for (int i = 0; i < 2; i++) begin
          if (g == i) begin
            if ($urandom_range(1, 0) == 0) rq[i] = 1'b0;
            ra[i] = 8'($urandom); rb[i] = 8'($urandom); ro[i] = 4'($urandom);
          end else if (!rq[i] && $urandom_range(9, 0) < 3) begin
            rq[i] = 1'b1;
            ra[i] = 8'($urandom); rb[i] = 8'($urandom); ro[i] = 4'($urandom);
          end
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
